// File: rtl/hilo_muldiv_if.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_if
//   Bundles the EX-stage request and the HI/LO result signals of the
//   multiply/divide unit.
//
//   Request (pipeline -> unit):
//     en          instruction valid and not annulled
//     flush       pipeline flush, aborts an in-flight divide
//     alucontrol  8-bit ALU decoder code
//     a, b        rs / rt operands
//   Response (unit -> pipeline):
//     stall_o       hold IF/ID/EX while a divide is unfinished
//     hi_o, lo_o    architectural HI / LO registers
//     hilo_rdata_o  MFHI/MFLO read data (0 for any other code)
// ---------------------------------------------------------------------------
interface hilo_muldiv_if;
    logic        en;
    logic        flush;
    logic [7:0]  alucontrol;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic [31:0] hilo_rdata_o;

    modport master (
        output en, flush, alucontrol, a, b,
        input  stall_o, hi_o, lo_o, hilo_rdata_o
    );

    modport slave (
        input  en, flush, alucontrol, a, b,
        output stall_o, hi_o, lo_o, hilo_rdata_o
    );
endinterface

// File: rtl/hilo_muldiv.sv
// ---------------------------------------------------------------------------
// hilo_muldiv
//   Execute-stage multiply/divide unit holding the HI/LO register pair.
//   MULT/MULTU and MTHI/MTLO complete in one cycle; DIV/DIVU run a 32-step
//   restoring divider and stall the pipeline until the result is written.
//   MFHI/MFLO are combinational reads of the current registers.
//
//   Ports:
//     clk   clock, all state changes on the rising edge
//     rst   synchronous active-high reset
//     bus   hilo_muldiv_if.slave (request inputs, stall and HI/LO outputs)
// ---------------------------------------------------------------------------
module hilo_muldiv (
    input  logic          clk,
    input  logic          rst,
    hilo_muldiv_if.slave  bus
);
    localparam logic [7:0] MFHI_CONTROL  = 8'b0001_0000;
    localparam logic [7:0] MTHI_CONTROL  = 8'b0001_0001;
    localparam logic [7:0] MFLO_CONTROL  = 8'b0001_0010;
    localparam logic [7:0] MTLO_CONTROL  = 8'b0001_0011;
    localparam logic [7:0] MULT_CONTROL  = 8'b0001_1000;
    localparam logic [7:0] MULTU_CONTROL = 8'b0001_1001;
    localparam logic [7:0] DIV_CONTROL   = 8'b0001_1010;
    localparam logic [7:0] DIVU_CONTROL  = 8'b0001_1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [4:0]  r_cnt;
    logic [63:0] r_rem;       // {partial remainder, unconsumed dividend bits}
    logic [31:0] r_quot;
    logic [31:0] r_divisor;
    logic        r_qneg;
    logic        r_rneg;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic w_op_valid;
    logic w_is_sdiv;
    logic w_is_div;
    logic w_b_zero;
    logic w_stall;

    assign w_op_valid = bus.en & ~bus.flush;
    assign w_is_sdiv  = (bus.alucontrol == DIV_CONTROL);
    assign w_is_div   = w_is_sdiv | (bus.alucontrol == DIVU_CONTROL);
    assign w_b_zero   = (bus.b == 32'd0);

    // ------------------------------------------------------------------
    // Multiplier: low 64 bits of the 64x64 product of the extended
    // operands give the signed or unsigned 64-bit result.
    // ------------------------------------------------------------------
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;

    assign w_prod_s = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
    assign w_prod_u = {32'd0, bus.a} * {32'd0, bus.b};

    // ------------------------------------------------------------------
    // Divider operand preparation. A zero divisor keeps the raw dividend
    // and no sign flags, so the plain restoring loop naturally yields
    // quotient all-ones and remainder equal to a.
    // ------------------------------------------------------------------
    logic [31:0] w_dividend;
    logic [31:0] w_divisor;
    logic        w_abs_a;

    assign w_abs_a    = w_is_sdiv & ~w_b_zero & bus.a[31];
    assign w_dividend = w_abs_a ? -bus.a : bus.a;
    assign w_divisor  = (w_is_sdiv & bus.b[31]) ? -bus.b : bus.b;

    // ------------------------------------------------------------------
    // One restoring shift-subtract step. The shifted remainder needs 33
    // bits because the remainder can reach divisor-1 before the shift.
    // ------------------------------------------------------------------
    logic [32:0] w_part;
    logic        w_ge;
    logic [31:0] w_sub;
    logic [63:0] w_rem_next;
    logic [31:0] w_quot_next;
    logic [31:0] w_lo_final;
    logic [31:0] w_hi_final;
    logic        w_cnt_last;

    assign w_part      = r_rem[63:31];
    assign w_ge        = (w_part >= {1'b0, r_divisor});
    assign w_sub       = w_part[31:0] - r_divisor;
    assign w_rem_next  = {(w_ge ? w_sub : w_part[31:0]), r_rem[30:0], 1'b0};
    assign w_quot_next = {r_quot[30:0], w_ge};
    assign w_lo_final  = r_qneg ? -w_quot_next : w_quot_next;
    assign w_hi_final  = r_rneg ? -w_rem_next[63:32] : w_rem_next[63:32];
    assign w_cnt_last  = (r_cnt == 5'd31);

    // ------------------------------------------------------------------
    // FSM next state and stall
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        w_state_next = r_state;
        w_stall      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_op_valid && w_is_div) begin
                    w_state_next = S_BUSY;
                    w_stall      = 1'b1;
                end
            end
            S_BUSY: begin
                w_stall = 1'b1;
                if (w_cnt_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        // A flush (or reset) releases the pipeline in the same cycle.
        if (bus.flush || rst) begin
            w_state_next = S_IDLE;
            w_stall      = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst) begin
            r_state   <= S_IDLE;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_cnt     <= 5'd0;
            r_rem     <= 64'd0;
            r_quot    <= 32'd0;
            r_divisor <= 32'd0;
            r_qneg    <= 1'b0;
            r_rneg    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (!bus.flush) begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.en) begin
                            case (bus.alucontrol)
                                MULT_CONTROL:  {r_hi, r_lo} <= w_prod_s;
                                MULTU_CONTROL: {r_hi, r_lo} <= w_prod_u;
                                MTHI_CONTROL:  r_hi <= bus.a;
                                MTLO_CONTROL:  r_lo <= bus.a;
                                DIV_CONTROL, DIVU_CONTROL: begin
                                    r_rem     <= {32'd0, w_dividend};
                                    r_quot    <= 32'd0;
                                    r_divisor <= w_divisor;
                                    r_qneg    <= w_is_sdiv & ~w_b_zero & (bus.a[31] ^ bus.b[31]);
                                    r_rneg    <= w_abs_a;
                                    r_cnt     <= 5'd0;
                                end
                                default: ;
                            endcase
                        end
                    end
                    S_BUSY: begin
                        r_rem  <= w_rem_next;
                        r_quot <= w_quot_next;
                        r_cnt  <= r_cnt + 5'd1;
                        if (w_cnt_last) begin
                            r_lo <= w_lo_final;
                            r_hi <= w_hi_final;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.stall_o = w_stall;
    assign bus.hi_o    = r_hi;
    assign bus.lo_o    = r_lo;
    assign bus.hilo_rdata_o = (bus.alucontrol == MFHI_CONTROL) ? r_hi :
                              (bus.alucontrol == MFLO_CONTROL) ? r_lo : 32'd0;
endmodule
